// File: rtl/shift_reg_checker.sv
// ============================================================================
// Module   : shift_reg_checker
// Purpose  : Cycle-accurate reference model and response checker for a 4-bit
//            shift/rotate/load register, with sticky failure capture.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_reg_checker #(
  parameter logic ENB_ACTIVE  = 1'b1,
  parameter int   STOP_ON_ERR = 0,
  parameter int   CNT_W       = 16,
  parameter int   ERR_W       = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENB,
  input  logic             DIR,
  input  logic             S_IN,
  input  logic [1:0]       MODO,
  input  logic [3:0]       D,
  input  logic [3:0]       Q,
  input  logic             S_OUT,
  output logic [3:0]       EXP_Q,
  output logic             EXP_S_OUT,
  output logic             SYNCED,
  output logic             ERR,
  output logic             FAIL,
  output logic [CNT_W-1:0] CHK_CNT,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic [3:0]       FIRST_EXP,
  output logic [3:0]       FIRST_GOT
);

  localparam logic [1:0] c_mode_shift  = 2'b00;
  localparam logic [1:0] c_mode_rotate = 2'b01;
  localparam logic [1:0] c_mode_load   = 2'b10;

  typedef enum logic [1:0] {
    ST_UNSYNC = 2'd0,
    ST_TRACK  = 2'd1,
    ST_FAIL   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [3:0]       r_exp_q;
  logic [3:0]       w_exp_q_next;
  logic             w_exp_s_out;
  logic             w_enabled;
  logic             w_load;
  logic             w_compare;
  logic             w_mismatch;
  logic             r_err;
  logic             r_fail;
  logic [CNT_W-1:0] r_chk_cnt;
  logic [ERR_W-1:0] r_err_cnt;
  logic [3:0]       r_first_exp;
  logic [3:0]       r_first_got;

  assign w_enabled   = (ENB == ENB_ACTIVE);
  assign w_load      = w_enabled && (MODO == c_mode_load);
  assign w_exp_s_out = DIR ? r_exp_q[0] : r_exp_q[3];
  assign w_compare   = (r_state == ST_TRACK);
  // Case-inequality so that unknown DUT bits are flagged as mismatches
  assign w_mismatch  = w_compare && ((Q !== r_exp_q) || (S_OUT !== w_exp_s_out));

  always_comb begin
    w_exp_q_next = r_exp_q;
    if (w_enabled) begin
      case (MODO)
        c_mode_shift:  w_exp_q_next = DIR ? {S_IN, r_exp_q[3:1]} : {r_exp_q[2:0], S_IN};
        c_mode_rotate: w_exp_q_next = DIR ? {r_exp_q[0], r_exp_q[3:1]}
                                          : {r_exp_q[2:0], r_exp_q[3]};
        c_mode_load:   w_exp_q_next = D;
        default:       w_exp_q_next = r_exp_q;
      endcase
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_UNSYNC: if (w_load) w_state_next = ST_TRACK;
      ST_TRACK:  if (w_mismatch && (STOP_ON_ERR != 0)) w_state_next = ST_FAIL;
      ST_FAIL:   w_state_next = ST_FAIL;
      default:   w_state_next = ST_UNSYNC;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_UNSYNC;
      r_exp_q <= 4'b0000;
    end else begin
      r_state <= w_state_next;
      r_exp_q <= w_exp_q_next;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_err       <= 1'b0;
      r_fail      <= 1'b0;
      r_chk_cnt   <= '0;
      r_err_cnt   <= '0;
      r_first_exp <= 4'b0000;
      r_first_got <= 4'b0000;
    end else begin
      r_err <= w_mismatch;
      if (w_compare && !(&r_chk_cnt)) begin
        r_chk_cnt <= r_chk_cnt + CNT_W'(1);
      end
      if (w_mismatch && !(&r_err_cnt)) begin
        r_err_cnt <= r_err_cnt + ERR_W'(1);
      end
      if (w_mismatch && !r_fail) begin
        r_fail      <= 1'b1;
        r_first_exp <= r_exp_q;
        r_first_got <= Q;
      end
    end
  end

  assign EXP_Q     = r_exp_q;
  assign EXP_S_OUT = w_exp_s_out;
  assign SYNCED    = (r_state != ST_UNSYNC);
  assign ERR       = r_err;
  assign FAIL      = r_fail;
  assign CHK_CNT   = r_chk_cnt;
  assign ERR_CNT   = r_err_cnt;
  assign FIRST_EXP = r_first_exp;
  assign FIRST_GOT = r_first_got;

endmodule

`default_nettype wire

// File: tb/tb_shift_reg_checker.sv
// ============================================================================
// Module   : tb_shift_reg_checker
// Purpose  : Directed vector bench for shift_reg_checker (three parameter sets).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_reg_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       enb, dir, s_in, s_out;
  logic [1:0] modo;
  logic [3:0] d, q;

  // u0: defaults, u1: stop on first error, u2: 2-bit error counter
  logic [3:0]  e_q0, e_q1, e_q2, fe0, fe1, fe2, fg0, fg1, fg2;
  logic        es0, es1, es2, sy0, sy1, sy2, er0, er1, er2, fl0, fl1, fl2;
  logic [15:0] cc0, cc1, cc2;
  logic [7:0]  ec0, ec1;
  logic [1:0]  ec2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_reg_checker u0 (
    .CLK(clk), .RESET(rst), .ENB(enb), .DIR(dir), .S_IN(s_in), .MODO(modo), .D(d),
    .Q(q), .S_OUT(s_out), .EXP_Q(e_q0), .EXP_S_OUT(es0), .SYNCED(sy0), .ERR(er0),
    .FAIL(fl0), .CHK_CNT(cc0), .ERR_CNT(ec0), .FIRST_EXP(fe0), .FIRST_GOT(fg0));

  shift_reg_checker #(.STOP_ON_ERR(1)) u1 (
    .CLK(clk), .RESET(rst), .ENB(enb), .DIR(dir), .S_IN(s_in), .MODO(modo), .D(d),
    .Q(q), .S_OUT(s_out), .EXP_Q(e_q1), .EXP_S_OUT(es1), .SYNCED(sy1), .ERR(er1),
    .FAIL(fl1), .CHK_CNT(cc1), .ERR_CNT(ec1), .FIRST_EXP(fe1), .FIRST_GOT(fg1));

  shift_reg_checker #(.ERR_W(2)) u2 (
    .CLK(clk), .RESET(rst), .ENB(enb), .DIR(dir), .S_IN(s_in), .MODO(modo), .D(d),
    .Q(q), .S_OUT(s_out), .EXP_Q(e_q2), .EXP_S_OUT(es2), .SYNCED(sy2), .ERR(er2),
    .FAIL(fl2), .CHK_CNT(cc2), .ERR_CNT(ec2), .FIRST_EXP(fe2), .FIRST_GOT(fg2));

  typedef struct {
    logic        enb, dir, s_in;
    logic [1:0]  modo;
    logic [3:0]  d, q;
    logic        s_out;
    logic [3:0]  exp_q;
    logic        exp_s;
    logic [15:0] chk;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    //            enb   dir   s_in  modo   d        q        s_out exp_q    exp_s chk
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 2'b10, 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0, 16'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 2'b00, 4'b0000, 4'b0001, 1'b0, 4'b0010, 1'b0, 16'd1};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 2'b00, 4'b0000, 4'b0010, 1'b0, 4'b0100, 1'b0, 16'd2};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 2'b00, 4'b0000, 4'b0100, 1'b0, 4'b1000, 1'b1, 16'd3};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 2'b00, 4'b0000, 4'b1000, 1'b1, 4'b0000, 1'b0, 16'd4};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 2'b11, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 16'd5};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 2'b10, 4'b0011, 4'b0000, 1'b0, 4'b0011, 1'b1, 16'd6};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 2'b01, 4'b0000, 4'b0011, 1'b1, 4'b1001, 1'b1, 16'd7};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 2'b01, 4'b0000, 4'b1001, 1'b1, 4'b1100, 1'b0, 16'd8};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 2'b01, 4'b0000, 4'b1100, 1'b0, 4'b0110, 1'b0, 16'd9};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 2'b01, 4'b0000, 4'b0110, 1'b0, 4'b0110, 1'b0, 16'd10};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 2'b00, 4'b0000, 4'b0110, 1'b0, 4'b1011, 1'b1, 16'd11};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 2'b01, 4'b0000, 4'b1011, 1'b1, 4'b0111, 1'b0, 16'd12};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 2'b00, 4'b0000, 4'b0111, 1'b0, 4'b1111, 1'b1, 16'd13};

    rst = 1'b1; enb = 1'b1; dir = 1'b0; s_in = 1'b0; modo = 2'b11;
    d = 4'b0000; q = 4'b0000; s_out = 1'b0;
    do_reset();

    check("reset exp_q", 32'(e_q0), 32'h0);
    check("reset synced", 32'(sy0), 32'h0);
    check("reset chk_cnt", 32'(cc0), 32'h0);
    check("reset fail", 32'(fl0), 32'h0);

    // Shift/rotate/load table with a well-behaved DUT
    for (int i = 0; i < 14; i++) begin
      enb = vecs[i].enb; dir = vecs[i].dir; s_in = vecs[i].s_in; modo = vecs[i].modo;
      d = vecs[i].d; q = vecs[i].q; s_out = vecs[i].s_out;
      tick();
      check($sformatf("vec%0d exp_q", i), 32'(e_q0), 32'(vecs[i].exp_q));
      check($sformatf("vec%0d exp_s_out", i), 32'(es0), 32'(vecs[i].exp_s));
      check($sformatf("vec%0d chk_cnt", i), 32'(cc0), 32'(vecs[i].chk));
      check($sformatf("vec%0d synced", i), 32'(sy0), 32'h1);
      check($sformatf("vec%0d err", i), 32'(er0), 32'h0);
      check($sformatf("vec%0d err_cnt", i), 32'(ec0), 32'h0);
    end
    check("table u1 fail", 32'(fl1), 32'h0);

    // No compares before a sync load
    do_reset();
    for (int i = 0; i < 5; i++) begin
      enb = (i < 4); modo = (i < 4) ? 2'b00 : 2'b10; d = 4'b1010;
      q = 4'(i * 5 + 3); s_out = i[0];
      tick();
      check($sformatf("unsync%0d synced", i), 32'(sy0), 32'h0);
      check($sformatf("unsync%0d err", i), 32'(er0), 32'h0);
    end
    check("unsync chk_cnt", 32'(cc0), 32'h0);

    // Single mismatch, then stop-on-error behaviour
    do_reset();
    enb = 1'b1; dir = 1'b0; modo = 2'b10; d = 4'b0100; q = 4'b0000; s_out = 1'b0;
    tick();
    modo = 2'b11; q = 4'b1111;
    check("err before edge", 32'(er0), 32'h0);
    tick();
    check("mm1 err", 32'(er0), 32'h1);
    check("mm1 err_cnt", 32'(ec0), 32'h1);
    check("mm1 fail", 32'(fl0), 32'h1);
    check("mm1 first_exp", 32'(fe0), 32'h4);
    check("mm1 first_got", 32'(fg0), 32'hf);
    check("mm1 u1 fail", 32'(fl1), 32'h1);
    q = 4'b0100;
    tick();
    check("ok err", 32'(er0), 32'h0);
    check("ok chk_cnt", 32'(cc0), 32'h2);
    check("ok u1 chk_cnt", 32'(cc1), 32'h1);
    q = 4'b0000;
    tick();
    check("mm2 err", 32'(er0), 32'h1);
    check("mm2 err_cnt", 32'(ec0), 32'h2);
    check("mm2 first_got", 32'(fg0), 32'hf);
    check("mm2 u1 err", 32'(er1), 32'h0);
    check("mm2 u1 err_cnt", 32'(ec1), 32'h1);
    check("mm2 u1 chk_cnt", 32'(cc1), 32'h1);
    check("mm2 u1 synced", 32'(sy1), 32'h1);
    enb = 1'b0; modo = 2'b10; d = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("hold%0d u1 exp_q", i), 32'(e_q1), 32'h4);
    end
    enb = 1'b1; modo = 2'b00; s_in = 1'b1;
    tick();
    check("u1 model in fail", 32'(e_q1), 32'h9);
    check("u1 chk frozen", 32'(cc1), 32'h1);
    rst = 1'b1;
    #1;
    check("async u1 exp_q", 32'(e_q1), 32'h0);
    check("async u1 synced", 32'(sy1), 32'h0);
    check("async u1 fail", 32'(fl1), 32'h0);
    check("async u1 err_cnt", 32'(ec1), 32'h0);
    check("async u1 chk_cnt", 32'(cc1), 32'h0);
    check("async u1 first_exp", 32'(fe1), 32'h0);
    check("async u1 first_got", 32'(fg1), 32'h0);
    check("async u0 err", 32'(er0), 32'h0);
    tick();
    rst = 1'b0;
    s_in = 1'b0;

    // Error counter saturation on a 2-bit counter
    modo = 2'b10; d = 4'b0101; q = 4'b0000; s_out = 1'b0;
    tick();
    modo = 2'b11;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: q = 4'b0000;
        1: q = 4'b1111;
        2: q = 4'b0001;
        3: q = 4'b1010;
        default: q = 4'b0110;
      endcase
      tick();
      check($sformatf("sat%0d err", i), 32'(er2), 32'h1);
      check($sformatf("sat%0d err_cnt", i), 32'(ec2), (i < 3) ? 32'(i + 1) : 32'h3);
    end
    check("sat first_exp", 32'(fe2), 32'h5);
    check("sat first_got", 32'(fg2), 32'h0);
    check("sat chk_cnt", 32'(cc2), 32'h5);
    check("sat u0 err_cnt", 32'(ec0), 32'h5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
